// File: rtl/cordic_rotation_ctrl.sv
// cordic_rotation_ctrl: sequencer wrapped around a rotation-mode `cordic` core.
// It accepts an angle, folds it into [-pi/2, pi/2], launches the core, waits
// for its done tick, restores the quadrant sign and hands cos/sin downstream.
// One transaction is in flight at a time.
// Optional watchdog on the core's done tick: define CORDIC_CTRL_TIMEOUT_EN.
module cordic_rotation_ctrl #(
  parameter int Width         = 16,
  parameter int FracBits      = 13,
  parameter int TimeoutCycles = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic signed [Width-1:0] angle_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic signed [Width-1:0] cos_o,
  output logic signed [Width-1:0] sin_o,
  output logic                    err_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic                    start_cordic_o,
  output logic signed [Width-1:0] x0_o,
  output logic signed [Width-1:0] y0_o,
  output logic signed [Width-1:0] z0_o,
  input  logic signed [Width-1:0] xn_i,
  input  logic signed [Width-1:0] yn_i,
  input  logic                    done_tick_cordic_i
);

  // Fixed-point constants, rounded to nearest at FracBits fractional bits.
  localparam real PiR   = 3.141592653589793;
  localparam real GainR = 0.6072529;
  localparam real Scale = 2.0 ** FracBits;

  localparam logic signed [Width-1:0] PI       = Width'($rtoi(PiR * Scale + 0.5));
  localparam logic signed [Width-1:0] NEG_PI   = -PI;
  localparam logic signed [Width-1:0] HALF_PI  = Width'($rtoi(PiR * Scale / 2.0 + 0.5));
  localparam logic signed [Width-1:0] NEG_HALF = -HALF_PI;
  localparam logic signed [Width-1:0] K        = Width'($rtoi(GainR * Scale + 0.5));

  localparam logic signed [Width-1:0] MAX_POS = {1'b0, {(Width-1){1'b1}}};
  localparam logic signed [Width-1:0] MIN_NEG = {1'b1, {(Width-1){1'b0}}};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  logic [1:0] state;
  logic       neg;

  // Two's-complement negation that maps the most negative code to the most
  // positive one instead of wrapping back onto itself.
  function automatic logic signed [Width-1:0] neg_sat(input logic signed [Width-1:0] v);
    if (v == MIN_NEG) begin
      return MAX_POS;
    end
    return -v;
  endfunction

  // Undo the half-turn applied at the front end: cos and sin both flip sign.
  function automatic logic signed [Width-1:0] quad_fix(input logic signed [Width-1:0] v,
                                                       input logic              flip);
    return flip ? neg_sat(v) : v;
  endfunction

`ifdef CORDIC_CTRL_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] wait_cnt;
`else
  // The timeout length has no role when the watchdog is compiled out.
  logic [31:0] unused_timeout;
  assign unused_timeout = TimeoutCycles;
`endif

  // Controller FSM together with all registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      neg            <= 1'b0;
      in_ready_o     <= 1'b1;
      out_valid_o    <= 1'b0;
      err_o          <= 1'b0;
      cos_o          <= '0;
      sin_o          <= '0;
      start_cordic_o <= 1'b0;
      x0_o           <= '0;
      y0_o           <= '0;
      z0_o           <= '0;
`ifdef CORDIC_CTRL_TIMEOUT_EN
      wait_cnt       <= '0;
`endif
    end else begin
      start_cordic_o <= 1'b0;
      case (state)
        // Front end: range check and quadrant folding of the accepted angle.
        IDLE: begin
          if (in_valid_i) begin
            in_ready_o <= 1'b0;
            x0_o       <= K;
            y0_o       <= '0;
            if ((angle_i > PI) || (angle_i < NEG_PI)) begin
              err_o       <= 1'b1;
              cos_o       <= '0;
              sin_o       <= '0;
              out_valid_o <= 1'b1;
              state       <= OUT;
            end else begin
              if (angle_i > HALF_PI) begin
                z0_o <= angle_i - PI;
                neg  <= 1'b1;
              end else if (angle_i < NEG_HALF) begin
                z0_o <= angle_i + PI;
                neg  <= 1'b1;
              end else begin
                z0_o <= angle_i;
                neg  <= 1'b0;
              end
              start_cordic_o <= 1'b1;
              state          <= START;
            end
          end
        end
        // Start pulse is on the output during this single cycle.
        START: begin
          state <= WAIT;
`ifdef CORDIC_CTRL_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        // Back end: capture the core result and restore the quadrant sign.
        WAIT: begin
          if (done_tick_cordic_i) begin
            cos_o       <= quad_fix(xn_i, neg);
            sin_o       <= quad_fix(yn_i, neg);
            err_o       <= 1'b0;
            out_valid_o <= 1'b1;
            state       <= OUT;
          end
`ifdef CORDIC_CTRL_TIMEOUT_EN
          else if (wait_cnt == CntLast) begin
            cos_o       <= '0;
            sin_o       <= '0;
            err_o       <= 1'b1;
            out_valid_o <= 1'b1;
            state       <= OUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        // Hold the result until the consumer takes it.
        OUT: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_rotation_ctrl.sv
// tb_cordic_rotation_ctrl: bench for cordic_rotation_ctrl in its default build.
// A behavioural stand-in for the `cordic` core answers each start pulse after a
// chosen delay, either with true trig values of z0 or with arbitrary codes so
// that the sign restoration (including saturation) can be checked exactly.
module tb_cordic_rotation_ctrl;

  localparam int W = 16;
  localparam int PI_Q = 25736;
  localparam int HALF_Q = 12868;
  localparam int K_Q = 4975;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic signed [W-1:0] angle = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] cos_v, sin_v;
  logic                err;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic                start_cordic;
  logic signed [W-1:0] x0, y0, z0;
  logic signed [W-1:0] xn = '0, yn = '0;
  logic                done = 1'b0;

  cordic_rotation_ctrl #(.Width(W), .FracBits(13), .TimeoutCycles(64)) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .angle_i           (angle),
    .in_valid_i        (in_valid),
    .in_ready_o        (in_ready),
    .cos_o             (cos_v),
    .sin_o             (sin_v),
    .err_o             (err),
    .out_valid_o       (out_valid),
    .out_ready_i       (out_ready),
    .start_cordic_o    (start_cordic),
    .x0_o              (x0),
    .y0_o              (y0),
    .z0_o              (z0),
    .xn_i              (xn),
    .yn_i              (yn),
    .done_tick_cordic_i(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Core stand-in configuration, set by the transaction task.
  bit                  trig_mode = 1'b1;
  int                  stub_delay = 1;
  logic signed [W-1:0] rand_xn = '0, rand_yn = '0;

  task automatic check_val(input string tag, input int obs, input int exp, input int tol = 0);
    n_vec++;
    if ((obs - exp > tol) || (exp - obs > tol)) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  function automatic int neg_clamp(input int v);
    int r;
    r = -v;
    if (r > 32767) r = 32767;
    return r;
  endfunction

  // Core stand-in: sees the start pulse, waits stub_delay cycles, ticks once.
  initial begin
    real zr;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        done = 1'b0;
        xn = W'($urandom);
        yn = W'($urandom);
      end
      if (rst_n && start_cordic) begin
        zr = real'(z0) / 8192.0;
        for (int i = 0; i < stub_delay && rst_n; i++) begin
          @(posedge clk);
          #1;
        end
        if (rst_n) begin
          if (trig_mode) begin
            xn = W'(rnd($cos(zr) * 8192.0));
            yn = W'(rnd($sin(zr) * 8192.0));
          end else begin
            xn = rand_xn;
            yn = rand_yn;
          end
          done = 1'b1;
        end
      end
    end
  end

  // One full transaction: offer angle, watch the core side, check result,
  // hold the result for 'hold' cycles, then complete the output handshake.
  task automatic run_txn(input int ang, input bit trig, input int dly, input int hold);
    int  exp_err, exp_neg, exp_z, exp_cos, exp_sin, tol;
    int  cyc, starts, done_cyc;
    bit  ov;
    real ar;
    exp_err = 0; exp_neg = 0; exp_z = ang; tol = 0;
    if (ang > PI_Q || ang < -PI_Q) exp_err = 1;
    else if (ang > HALF_Q) begin exp_z = ang - PI_Q; exp_neg = 1; end
    else if (ang < -HALF_Q) begin exp_z = ang + PI_Q; exp_neg = 1; end

    trig_mode = trig;
    stub_delay = dly;
    if (!trig) begin
      rand_xn = ($urandom_range(0, 5) == 0) ? W'(-32768) : W'($urandom);
      rand_yn = ($urandom_range(0, 5) == 0) ? W'(-32768) : W'($urandom);
    end

    if (exp_err) begin
      exp_cos = 0; exp_sin = 0;
    end else if (trig) begin
      ar = real'(ang) / 8192.0;
      exp_cos = rnd($cos(ar) * 8192.0);
      exp_sin = rnd($sin(ar) * 8192.0);
      tol = 4;
    end else begin
      exp_cos = exp_neg ? neg_clamp(int'(rand_xn)) : int'(rand_xn);
      exp_sin = exp_neg ? neg_clamp(int'(rand_yn)) : int'(rand_yn);
    end

    @(negedge clk);
    angle = W'(ang);
    in_valid = 1'b1;
    check_val("in_ready_idle", int'(in_ready), 1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    angle = W'($urandom);

    cyc = 0; starts = 0; done_cyc = -10; ov = 1'b0;
    while (!ov && cyc < 300) begin
      if (start_cordic) begin
        starts++;
        if (starts == 1) begin
          check_val("start_latency", cyc, 0);
          check_val("z0", int'(z0), exp_z);
          check_val("x0", int'(x0), K_Q);
          check_val("y0", int'(y0), 0);
        end
      end
      if (done) done_cyc = cyc;
      if (out_valid) ov = 1'b1;
      else begin
        @(posedge clk);
        #2;
        cyc++;
      end
    end
    check_val("out_valid_seen", int'(ov), 1);
    check_val("start_count", starts, exp_err ? 0 : 1);
    if (!exp_err) check_val("out_latency", cyc, done_cyc + 1);
    check_val("err", int'(err), exp_err);
    check_val("cos", int'(cos_v), exp_cos, tol);
    check_val("sin", int'(sin_v), exp_sin, tol);
    check_val("in_ready_busy", int'(in_ready), 0);

    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      angle = W'($urandom);
      @(posedge clk);
      #2;
      check_val("hold_valid", int'(out_valid), 1);
      check_val("hold_cos", int'(cos_v), exp_cos, tol);
      check_val("hold_in_ready", int'(in_ready), 0);
      check_val("hold_no_start", int'(start_cordic), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    check_val("valid_cleared", int'(out_valid), 0);
    check_val("in_ready_back", int'(in_ready), 1);
  endtask

  initial begin
    int a;
    int bounds[10] = '{25736, -25736, 25737, -25737, 12868, 12869, -12868, -12869, -32768, 32767};

    repeat (3) @(posedge clk);
    #2;
    check_val("rst_in_ready", int'(in_ready), 1);
    check_val("rst_out_valid", int'(out_valid), 0);
    check_val("rst_start", int'(start_cordic), 0);
    check_val("rst_err", int'(err), 0);
    check_val("rst_x0", int'(x0), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed angles with trig-valued core answers.
    run_txn(0, 1'b1, 3, 0);
    run_txn(19302, 1'b1, 5, 0);
    run_txn(12868, 1'b1, 2, 0);
    run_txn(-25736, 1'b1, 4, 0);
    run_txn(26000, 1'b1, 3, 0);
    run_txn(19302, 1'b1, 3, 10);

    // Range and fold boundaries with arbitrary core codes.
    foreach (bounds[i]) run_txn(bounds[i], 1'b0, $urandom_range(1, 6), $urandom_range(0, 2));

    // Randomized angles, delays and back-pressure.
    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(0, 65535)) - 32768;
      run_txn(a, ($urandom_range(0, 1) == 1), $urandom_range(1, 8), $urandom_range(0, 3));
    end

    // Reset while waiting on the core.
    trig_mode = 1'b1;
    stub_delay = 100;
    @(negedge clk);
    angle = W'(1000);
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check_val("pre_rst_z0", int'(z0), 1000);
    rst_n = 1'b0;
    #1;
    check_val("arst_in_ready", int'(in_ready), 1);
    check_val("arst_out_valid", int'(out_valid), 0);
    check_val("arst_z0", int'(z0), 0);
    check_val("arst_x0", int'(x0), 0);
    check_val("arst_cos", int'(cos_v), 0);
    check_val("arst_err", int'(err), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(-19302, 1'b1, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
